// File: rtl/quad_velocity_estimator_if.sv
// Bus between the quadrature velocity estimator and its firmware-facing side:
// position input, run/ack controls and the registered velocity snapshot.
interface quad_velocity_estimator_if;
  logic [31:0] count_in;
  logic        enable;
  logic        ack;
  logic [15:0] vel1;
  logic [15:0] vel2;
  logic [15:0] filt1;
  logic [15:0] filt2;
  logic [31:0] pos_snap;
  logic        vel_valid;
  logic        data_ready;
  logic        overrun;
  logic [7:0]  seq;

  modport master (
    output count_in, enable, ack,
    input  vel1, vel2, filt1, filt2, pos_snap, vel_valid, data_ready, overrun, seq
  );

  modport slave (
    input  count_in, enable, ack,
    output vel1, vel2, filt1, filt2, pos_snap, vel_valid, data_ready, overrun, seq
  );
endinterface

// File: rtl/quad_velocity_estimator.sv
// Dual-channel periodic velocity estimator: wrap-aware position deltas, IIR smoothing and a
// sticky ready/overrun snapshot handshake towards firmware.
module quad_velocity_estimator #(
  parameter int unsigned SAMPLE_CYCLES = 100000,
  parameter int unsigned FILT_SHIFT    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  quad_velocity_estimator_if.slave  bus
);

  localparam int unsigned TimerW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {StPrime, StSeed, StRun} state_e;

  state_e state_q, state_d;

  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       prev1_q, prev1_d, prev2_q, prev2_d;
  logic [15:0]       vel1_q, vel1_d, vel2_q, vel2_d;
  logic [15:0]       filt1_q, filt1_d, filt2_q, filt2_d;
  logic [31:0]       pos_snap_q, pos_snap_d;
  logic              vel_valid_q, vel_valid_d;
  logic              data_ready_q, data_ready_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        seq_q, seq_d;

  logic              tick;
  logic              upd;
  logic [15:0]       curr1, curr2;
  logic [15:0]       delta1, delta2;

  // 17-bit signed difference so the arithmetic shift floors correctly; result wraps at 16 bits.
  function automatic logic [15:0] filt_step(input logic [15:0] delta, input logic [15:0] filt);
    logic signed [16:0] diff;
    diff = $signed({delta[15], delta}) - $signed({filt[15], filt});
    return filt + 16'(diff >>> FILT_SHIFT);
  endfunction

  assign tick   = bus.enable && (timer_q == TimerW'(SAMPLE_CYCLES - 1));
  assign upd    = tick && (state_q != StPrime);
  assign curr1  = bus.count_in[15:0];
  assign curr2  = bus.count_in[31:16];
  // Modulo-2^16 subtraction makes the 0xFFFF/0x0000 encoder wrap seamless.
  assign delta1 = curr1 - prev1_q;
  assign delta2 = curr2 - prev2_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPrime;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = StPrime;
    end else if (tick) begin
      unique case (state_q)
        StPrime: state_d = StSeed;
        StSeed:  state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StPrime;
      endcase
    end
  end

  // Datapath / output next-state logic
  always_comb begin
    timer_d      = timer_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    vel1_d       = vel1_q;
    vel2_d       = vel2_q;
    filt1_d      = filt1_q;
    filt2_d      = filt2_q;
    pos_snap_d   = pos_snap_q;
    vel_valid_d  = upd;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    seq_d        = seq_q;

    if (!bus.enable) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    if (tick) begin
      prev1_d = curr1;
      prev2_d = curr2;
    end

    if (upd) begin
      vel1_d     = delta1;
      vel2_d     = delta2;
      pos_snap_d = bus.count_in;
      seq_d      = seq_q + 8'd1;
      if (state_q == StSeed) begin
        filt1_d = delta1;
        filt2_d = delta2;
      end else begin
        filt1_d = filt_step(delta1, filt1_q);
        filt2_d = filt_step(delta2, filt2_q);
      end
    end

    // A new snapshot takes priority over a coincident acknowledge.
    if (upd) begin
      data_ready_d = 1'b1;
    end else if (bus.ack) begin
      data_ready_d = 1'b0;
    end

    if (upd && data_ready_q && !bus.ack) begin
      overrun_d = 1'b1;
    end else if (bus.ack && data_ready_q) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      vel1_q       <= '0;
      vel2_q       <= '0;
      filt1_q      <= '0;
      filt2_q      <= '0;
      pos_snap_q   <= '0;
      vel_valid_q  <= 1'b0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      seq_q        <= '0;
    end else begin
      timer_q      <= timer_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      vel1_q       <= vel1_d;
      vel2_q       <= vel2_d;
      filt1_q      <= filt1_d;
      filt2_q      <= filt2_d;
      pos_snap_q   <= pos_snap_d;
      vel_valid_q  <= vel_valid_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      seq_q        <= seq_d;
    end
  end

  // Output drive
  always_comb begin
    bus.vel1       = vel1_q;
    bus.vel2       = vel2_q;
    bus.filt1      = filt1_q;
    bus.filt2      = filt2_q;
    bus.pos_snap   = pos_snap_q;
    bus.vel_valid  = vel_valid_q;
    bus.data_ready = data_ready_q;
    bus.overrun    = overrun_q;
    bus.seq        = seq_q;
  end

endmodule

// File: tb/tb_quad_velocity_estimator.sv
// Directed test of quad_velocity_estimator with SAMPLE_CYCLES=10: one instance with
// FILT_SHIFT=2 and a second with FILT_SHIFT=0 sharing the same inputs.
module tb_quad_velocity_estimator;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cycles;
  int   pulses;

  quad_velocity_estimator_if a ();
  quad_velocity_estimator_if b ();

  assign b.count_in = a.count_in;
  assign b.enable   = a.enable;
  assign b.ack      = a.ack;

  quad_velocity_estimator #(.SAMPLE_CYCLES(10), .FILT_SHIFT(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  quad_velocity_estimator #(.SAMPLE_CYCLES(10), .FILT_SHIFT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until vel_valid is seen or the budget runs out.
  task automatic wait_update(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!a.vel_valid && waited < budget);
    check("update_seen", {31'd0, a.vel_valid}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    a.enable   = 1'b0;
    a.ack      = 1'b0;
    a.count_in = 32'h8000_8000;
    idle(3);
    check("rst_vel1", a.vel1, 0);
    check("rst_filt1", a.filt1, 0);
    check("rst_pos", a.pos_snap, 0);
    check("rst_seq", a.seq, 0);
    check("rst_ready", {a.data_ready, a.overrun, a.vel_valid}, 0);

    // PRIME then SEED: first update at the second tick.
    rst      = 1'b0;
    a.enable = 1'b1;
    wait_update(40, cycles);
    check("first_update_latency", cycles, 20);
    check("seed_vel", {a.vel2, a.vel1}, 0);
    check("seed_filt", {a.filt2, a.filt1}, 0);
    check("seed_seq", a.seq, 1);
    check("seed_ready", {a.data_ready, a.overrun}, 2'b10);
    check("seed_pos", a.pos_snap, 32'h8000_8000);

    // Second update without ack raises overrun.
    a.count_in = {16'h0010, 16'hFFF0};
    wait_update(15, cycles);
    check("ovr_period", cycles, 10);
    check("ovr_flags", {a.data_ready, a.overrun}, 2'b11);
    check("ovr_seq", a.seq, 2);
    a.ack = 1'b1;
    @(negedge clk);
    a.ack = 1'b0;
    @(negedge clk);
    check("ack_clears", {a.data_ready, a.overrun}, 2'b00);

    a.count_in = {16'hFFF0, 16'h0010};
    wait_update(15, cycles);
    check("wrap_fwd_vel1", a.vel1, 16'h0020);
    check("wrap_rev_vel2", a.vel2, 16'hFFE0);
    check("wrap_seq", a.seq, 3);
    check("wrap_flags", {a.data_ready, a.overrun}, 2'b10);

    // Reset the cycle after the tick kills the pending pulse and all state.
    rst = 1'b1;
    @(negedge clk);
    check("rst2_valid", a.vel_valid, 0);
    check("rst2_vel", {a.vel2, a.vel1}, 0);
    check("rst2_seq", a.seq, 0);
    check("rst2_pos", a.pos_snap, 0);
    rst        = 1'b0;
    a.count_in = {16'd0, 16'd1000};
    wait_update(40, cycles);
    check("rst2_latency", cycles, 20);
    check("rst2_seed_vel1", a.vel1, 0);
    check("rst2_seed_filt1", a.filt1, 0);
    check("rst2_seed_seq", a.seq, 1);

    // Filter step response to a constant +100 per period.
    a.count_in = {16'd0, 16'd1100};
    wait_update(15, cycles);
    check("step1_vel1", a.vel1, 100);
    check("step1_filt1", a.filt1, 25);
    check("k0_step1_filt1", b.filt1, 100);
    a.count_in = {16'd0, 16'd1200};
    wait_update(15, cycles);
    check("step2_filt1", a.filt1, 43);
    check("k0_step2_filt1", b.filt1, 100);
    a.count_in = {16'd0, 16'd1300};
    wait_update(15, cycles);
    check("step3_filt1", a.filt1, 57);
    check("step3_vel2", a.vel2, 0);
    check("step3_seq", a.seq, 4);
    check("step3_flags", {a.data_ready, a.overrun}, 2'b11);

    // Ack coincident with the next update: ready stays, overrun clears.
    a.count_in = {16'd0, 16'd1400};
    idle(9);
    a.ack = 1'b1;
    @(negedge clk);
    a.ack = 1'b0;
    check("coinc_valid", a.vel_valid, 1);
    check("coinc_flags", {a.data_ready, a.overrun}, 2'b10);
    check("step4_filt1", a.filt1, 67);
    check("k0_step4_filt1", b.filt1, 100);

    // Enable drop at timer=5 for 20 cycles: no updates, outputs hold.
    idle(5);
    a.enable   = 1'b0;
    a.count_in = {16'd0, 16'd5000};
    pulses     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a.vel_valid) pulses++;
    end
    check("dis_no_pulse", pulses, 0);
    check("dis_hold_vel1", a.vel1, 100);
    check("dis_hold_filt1", a.filt1, 67);
    check("dis_hold_seq", a.seq, 5);
    check("dis_hold_pos", a.pos_snap, {16'd0, 16'd1400});
    a.enable = 1'b1;
    wait_update(40, cycles);
    check("reen_latency", cycles, 20);
    check("reen_vel1", a.vel1, 0);
    check("reen_filt1", a.filt1, 0);
    check("reen_seq", a.seq, 6);
    check("reen_flags", {a.data_ready, a.overrun}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
